// File: rtl/fib_pkg.sv
// Shared types and sizing helpers for the Zeckendorf decomposer.
// fib_code_width(W) = number of Fibonacci terms F(2).. that fit below 2**W.
package fib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASCEND  = 2'd1,
        ST_DESCEND = 2'd2,
        ST_DONE    = 2'd3
    } fib_state_e;

    function automatic int fib_code_width(input int width);
        logic [63:0] lim;
        logic [63:0] fa;
        logic [63:0] fb;
        logic [63:0] ft;
        int          n;
        lim = (64'd1 << width) - 64'd1;
        fa  = 64'd1;
        fb  = 64'd2;
        n   = 1;
        for (int i = 0; i < 64; i++) begin
            if (fb <= lim) begin
                ft = fa + fb;
                fa = fb;
                fb = ft;
                n  = n + 1;
            end
        end
        return n;
    endfunction

    localparam int CODE_W = fib_code_width(32);

endpackage

// File: rtl/fib_step.sv
// Fibonacci pair walker: (a,b) = (F(idx+2), F(idx+3)) stepped up or down,
// with magnitude compares against the running remainder.
module fib_step
    import fib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_up,
    input  logic             i_down,
    input  logic [WIDTH-1:0] i_rem,
    output logic [WIDTH-1:0] o_a,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_a_le_rem,
    output logic             o_b_le_rem,
    output logic             o_idx_zero
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH:0]   r_b;
    logic [IDX_W-1:0] r_idx;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;

    // b carries one extra bit so a+b is exact; a only ever takes a b that was <= rem.
    assign w_sum  = {1'b0, r_a} + r_b;
    assign w_diff = r_b[WIDTH-1:0] - r_a;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= WIDTH'(1);
            r_b   <= (WIDTH+1)'(2);
            r_idx <= '0;
        end else if (i_load) begin
            r_a   <= WIDTH'(1);
            r_b   <= (WIDTH+1)'(2);
            r_idx <= '0;
        end else if (i_up) begin
            r_a   <= r_b[WIDTH-1:0];
            r_b   <= w_sum;
            r_idx <= r_idx + 1'b1;
        end else if (i_down) begin
            r_a   <= w_diff;
            r_b   <= {1'b0, r_a};
            r_idx <= r_idx - 1'b1;
        end
    end

    assign o_a        = r_a;
    assign o_idx      = r_idx;
    assign o_a_le_rem = (r_a <= i_rem);
    assign o_b_le_rem = (r_b <= {1'b0, i_rem});
    assign o_idx_zero = (r_idx == '0);

endmodule

// File: rtl/fib_zeckendorf.sv
// Greedy Zeckendorf decomposition: ascend to the largest F <= Value, then descend.
// Optional self-checker compiled in with FIB_ZECKENDORF_CHECK_EN.
module fib_zeckendorf
    import fib_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             Start,
    input  logic [WIDTH-1:0]                 Value,
    output logic                             Busy,
    output logic                             Done,
    output logic [fib_code_width(WIDTH)-1:0] Code,
    output logic [5:0]                       Terms,
    output logic                             Error
);

    localparam int CW    = fib_code_width(WIDTH);
    localparam int IDX_W = $clog2(CW);

    fib_state_e       r_state;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_code;
    logic [5:0]       r_terms;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_up;
    logic             w_down;
    logic [WIDTH-1:0] w_a;
    logic [IDX_W-1:0] w_idx;
    logic             w_a_le_rem;
    logic             w_b_le_rem;
    logic             w_idx_zero;

    assign w_load = (r_state == ST_IDLE) && Start;
    assign w_up   = (r_state == ST_ASCEND) && w_b_le_rem;
    assign w_down = (r_state == ST_DESCEND) && !w_idx_zero;

    fib_step #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_step (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_load     (w_load),
        .i_up       (w_up),
        .i_down     (w_down),
        .i_rem      (r_rem),
        .o_a        (w_a),
        .o_idx      (w_idx),
        .o_a_le_rem (w_a_le_rem),
        .o_b_le_rem (w_b_le_rem),
        .o_idx_zero (w_idx_zero)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_code  <= '0;
            r_terms <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_rem   <= Value;
                        r_code  <= '0;
                        r_terms <= '0;
                        r_busy  <= 1'b1;
                        if (Value == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ASCEND;
                        end
                    end
                end
                ST_ASCEND: begin
                    if (!w_b_le_rem) begin
                        r_state <= ST_DESCEND;
                    end
                end
                ST_DESCEND: begin
                    if (w_a_le_rem) begin
                        r_rem         <= r_rem - w_a;
                        r_code[w_idx] <= 1'b1;
                        r_terms       <= r_terms + 6'd1;
                    end
                    if (w_idx_zero) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy  = r_busy;
    assign Done  = r_done;
    assign Code  = r_code;
    assign Terms = r_terms;

`ifdef FIB_ZECKENDORF_CHECK_EN
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_value;
    logic             r_error;

    // Terms taken must add back to the request and never sit in adjacent positions.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_acc   <= '0;
            r_value <= '0;
            r_error <= 1'b0;
        end else if (w_load) begin
            r_acc   <= '0;
            r_value <= Value;
            r_error <= 1'b0;
        end else if (r_state == ST_DESCEND && w_a_le_rem) begin
            r_acc <= r_acc + w_a;
        end else if (r_state == ST_DONE) begin
            r_error <= (r_acc != r_value) || (|(r_code & (r_code >> 1)));
        end
    end

    assign Error = r_error;
`else
    assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_fib_zeckendorf.sv
// Directed bench for fib_zeckendorf: hand-derived codes, term counts and latencies.
module tb_fib_zeckendorf;

    localparam int WIDTH = 32;
    localparam int CW    = 46;

    logic             CLK   = 1'b0;
    logic             RST_N = 1'b0;
    logic             Start = 1'b0;
    logic [WIDTH-1:0] Value = '0;
    logic             Busy;
    logic             Done;
    logic [CW-1:0]    Code;
    logic [5:0]       Terms;
    logic             Error;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] fib_tab [0:CW-1];

    fib_zeckendorf #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .Start (Start),
        .Value (Value),
        .Busy  (Busy),
        .Done  (Done),
        .Code  (Code),
        .Terms (Terms),
        .Error (Error)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [63:0] decode(input logic [CW-1:0] c);
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < CW; i++) begin
            if (c[i]) s = s + fib_tab[i];
        end
        return s;
    endfunction

    // inj >= 0 pulses a competing Start (Value=5) that many cycles into the job.
    task automatic run_job(input string tag, input logic [WIDTH-1:0] v,
                           input logic [CW-1:0] exp_code, input int exp_terms,
                           input int exp_lat, input int inj);
        int lat;
        @(negedge CLK);
        Value = v;
        Start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        lat   = 0;
        while (Done !== 1'b1 && lat < 300) begin
            @(negedge CLK);
            Start = 1'b0;
            lat++;
            if (lat == inj) begin
                check($sformatf("%s_busy", tag), 64'(Busy), 64'd1);
                Value = 32'd5;
                Start = 1'b1;
            end
        end
        Start = 1'b0;
        check($sformatf("%s_done", tag), 64'(Done), 64'd1);
        check($sformatf("%s_latency", tag), 64'(lat), 64'(exp_lat));
        check($sformatf("%s_code", tag), 64'(Code), 64'(exp_code));
        check($sformatf("%s_terms", tag), 64'(Terms), 64'(exp_terms));
        check($sformatf("%s_sum", tag), decode(Code), 64'(v));
        check($sformatf("%s_adjacent", tag), 64'(Code & (Code >> 1)), 64'd0);
        @(negedge CLK);
        check($sformatf("%s_done_pulse", tag), 64'(Done), 64'd0);
        check($sformatf("%s_idle", tag), 64'(Busy), 64'd0);
        check($sformatf("%s_error", tag), 64'(Error), 64'd0);
    endtask

    initial begin
        logic done_seen;

        fib_tab[0] = 64'd1;
        fib_tab[1] = 64'd2;
        for (int i = 2; i < CW; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];

        repeat (3) @(negedge CLK);
        check("rst_busy",  64'(Busy),  64'd0);
        check("rst_done",  64'(Done),  64'd0);
        check("rst_code",  64'(Code),  64'd0);
        check("rst_terms", 64'(Terms), 64'd0);
        check("rst_error", 64'(Error), 64'd0);
        RST_N = 1'b1;

        // 100 = 89 + 8 + 3, ascends 9 times
        run_job("v100", 32'd100, 46'h214, 3, 20, -1);
        repeat (4) @(negedge CLK);
        check("v100_hold_code",  64'(Code),  64'h214);
        check("v100_hold_terms", 64'(Terms), 64'd3);

        run_job("v0", 32'd0, 46'h0, 0, 0, -1);
        run_job("v1", 32'd1, 46'h1, 1, 2, -1);
        // 4000000 = F33+F28+F26+F23+F20+F15+F12+F9+F6
        run_job("v4m", 32'd4000000, 46'h85242490, 9, 64, -1);
        // all-ones tops out at F(47) = 2971215073, bit 45
        run_job("vmax", 32'hFFFF_FFFF, 46'h2885_4510_1124, 13, 92, -1);
        check("vmax_bit45", 64'(Code[45]), 64'd1);

        run_job("ignore", 32'd100, 46'h214, 3, 20, 3);

        // Abandon a job partway through the descent
        @(negedge CLK);
        Value = 32'd100;
        Start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        repeat (14) @(negedge CLK);
        check("mid_busy", 64'(Busy), 64'd1);
        check("mid_code", 64'(Code), 64'h200);
        #1 RST_N = 1'b0;
        #1;
        check("arst_busy",  64'(Busy),  64'd0);
        check("arst_code",  64'(Code),  64'd0);
        check("arst_terms", 64'(Terms), 64'd0);
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (Done) done_seen = 1'b1;
        end
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (Done) done_seen = 1'b1;
        end
        check("arst_no_done", 64'(done_seen), 64'd0);

        run_job("after_rst", 32'd100, 46'h214, 3, 20, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
